pmcc_shift_sequencer: RTL and testbench
=======================================

PMCC_SHIFT_SEQUENCER -- requirements
Module: pmcc_shift_sequencer

Interface
REQ-001 SHALL have clk  input  1  system clock; all logic on its rising edge.
REQ-002 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have start  input  1  single-cycle request to begin a shift sequence.
REQ-004 SHALL have abort  input  1  synchronous request to terminate the current sequence.
REQ-005 SHALL have bit_count  input  10  number of bits per lane to shift; sampled on accepted start.
REQ-006 SHALL have half_period  input  8  clkSh half-period in clk cycles; sampled on accepted start; 0 is treated as 1.
REQ-007 SHALL have din  input  32  data word: [15:0] feeds shA, [31:16] feeds shB, LSB first.
REQ-008 SHALL have din_valid  input  1  din holds a valid word.
REQ-009 SHALL have din_ready  output  1  sequencer accepts din this cycle.
REQ-010 SHALL have clk_sh  output  1  pixel-matrix shift clock.
REQ-011 SHALL have sh_a  output  1  serial data for shift register A.
REQ-012 SHALL have sh_b  output  1  serial data for shift register B.
REQ-013 SHALL have strobe  output  1  end-of-sequence latch strobe.
REQ-014 SHALL have busy  output  1  high in every state except IDLE.
REQ-015 SHALL have done  output  1  one-cycle pulse on sequence completion.

Function
REQ-016 SHALL implement states IDLE, LOAD, SETUP, HIGH, STROBE, DONE.
REQ-017 IDLE: start=1 with bit_count>0 SHALL go to LOAD next cycle; start with bit_count=0 SHALL go to DONE (no clk_sh pulses); start while busy SHALL be ignored.
REQ-018 LOAD: din_ready=1; on din_valid&din_ready the word SHALL be captured and the FSM SHALL enter SETUP next cycle; without din_valid it SHALL wait in LOAD with clk_sh=0.
REQ-019 SETUP: clk_sh=0, sh_a/sh_b SHALL drive the current bit for exactly H cycles (H=max(half_period,1)), then enter HIGH.
REQ-020 HIGH: clk_sh=1 for exactly H cycles, sh_a/sh_b held stable; on exit the bit counter SHALL increment.
REQ-021 After HIGH: if bits shifted == bit_count, SHALL go to STROBE (macro set) or DONE; else if 16 bits of the current word are used, SHALL go to LOAD; else SHALL go to SETUP with next bit.
REQ-022 Bits of the final word beyond bit_count SHALL be discarded.
REQ-023 STROBE: strobe=1, clk_sh=0 for H cycles, then DONE.
REQ-024 DONE: done=1 for one cycle, then IDLE.
REQ-025 abort=1 in any state SHALL force IDLE next cycle with clk_sh, sh_a, sh_b, strobe, din_ready=0 and no done pulse; abort has priority over start.
REQ-026 Outputs SHALL be registered (no combinational path from inputs to clk_sh, sh_a, sh_b, strobe).

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, counters and data register to 0, and all outputs to 0.
REQ-028 Reset mid-sequence SHALL abandon the sequence without a done pulse.

Configuration
REQ-029 With PMCC_SEQ_STROBE_EN defined the STROBE state SHALL be included per REQ-023; without it STROBE SHALL not exist, strobe SHALL be tied 0 and completion SHALL go directly to DONE.

Verification
REQ-030 half_period=2, bit_count=4, din=0x0005_000A -> 4 clk_sh pulses, 2 cycles low/2 high each; sh_a=0,1,0,1; sh_b=1,0,1,0; done once.
REQ-031 bit_count=20, din_valid deasserted 10 cycles after first word -> clk_sh held low in LOAD, resumes with second word bit0; exactly 20 pulses total.
REQ-032 bit_count=0, start -> done pulse 1 cycle after start, no clk_sh/din_ready activity.
REQ-033 abort during HIGH of bit 3 -> clk_sh=0, busy=0 next cycle, no done; new start then runs normally.
REQ-034 half_period=0, bit_count=2, macro defined -> 1-cycle low/high phases, strobe high 1 cycle before done; macro undefined -> strobe never asserted.
REQ-035 rst_n pulsed low mid-sequence -> all outputs 0 immediately, busy=0, no done.

Source files
------------

// File: rtl/pmcc_shift_sequencer.sv
// Pixel-matrix shift sequencer: serialises 16-bit lane pairs onto sh_a/sh_b under a slow clk_sh.
// Optional end-of-sequence latch strobe enabled by defining PMCC_SEQ_STROBE_EN.
module pmcc_shift_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  bit_count,
    input  logic [7:0]  half_period,
    input  logic [31:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        clk_sh,
    output logic        sh_a,
    output logic        sh_b,
    output logic        strobe,
    output logic        busy,
    output logic        done
);
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned HP_W   = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETUP  = 3'd2,
        S_HIGH   = 3'd3,
        S_DONE   = 3'd4
`ifdef PMCC_SEQ_STROBE_EN
        ,
        S_STROBE = 3'd5
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_a_q, word_a_d, word_b_q, word_b_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    shifted_q, shifted_d, count_q, count_d;
    logic [HP_W-1:0]     half_q, half_d, phase_q, phase_d;
    logic                phase_end, last_bit, word_end;
    logic                busy_d, done_d, din_ready_d, clk_sh_d, sh_a_d, sh_b_d;

    assign phase_end = (phase_q == HP_W'(half_q - HP_W'(1)));
    assign last_bit  = (CNT_W'(shifted_q + CNT_W'(1)) == count_q);
    assign word_end  = (idx_q == IDX_W'(WORD_W - 1));

    // State, datapath and registered outputs; outputs are decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            word_a_q  <= '0;
            word_b_q  <= '0;
            idx_q     <= '0;
            shifted_q <= '0;
            count_q   <= '0;
            half_q    <= '0;
            phase_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            din_ready <= 1'b0;
            clk_sh    <= 1'b0;
            sh_a      <= 1'b0;
            sh_b      <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_a_q  <= word_a_d;
            word_b_q  <= word_b_d;
            idx_q     <= idx_d;
            shifted_q <= shifted_d;
            count_q   <= count_d;
            half_q    <= half_d;
            phase_q   <= phase_d;
            busy      <= busy_d;
            done      <= done_d;
            din_ready <= din_ready_d;
            clk_sh    <= clk_sh_d;
            sh_a      <= sh_a_d;
            sh_b      <= sh_b_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        word_a_d  = word_a_q;
        word_b_d  = word_b_q;
        idx_d     = idx_q;
        shifted_d = shifted_q;
        count_d   = count_q;
        half_d    = half_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d   = bit_count;
                    half_d    = (half_period == '0) ? HP_W'(1) : half_period;
                    shifted_d = '0;
                    state_d   = (bit_count == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (din_valid) begin
                    word_a_d = din[15:0];
                    word_b_d = din[31:16];
                    idx_d    = '0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_end) state_d = S_HIGH;
            end
            S_HIGH: begin
                if (phase_end) begin
                    shifted_d = CNT_W'(shifted_q + CNT_W'(1));
                    idx_d     = IDX_W'(idx_q + IDX_W'(1));
                    word_a_d  = word_a_q >> 1;
                    word_b_d  = word_b_q >> 1;
                    if (last_bit) begin
`ifdef PMCC_SEQ_STROBE_EN
                        state_d = S_STROBE;
`else
                        state_d = S_DONE;
`endif
                    end else if (word_end) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
`ifdef PMCC_SEQ_STROBE_EN
            S_STROBE: begin
                if (phase_end) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
        // Phase counter restarts on every state change
        phase_d = (state_d != state_q) ? '0 : HP_W'(phase_q + HP_W'(1));
    end

    // Output decode of the upcoming state
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        din_ready_d = (state_d == S_LOAD);
        clk_sh_d    = (state_d == S_HIGH);
        sh_a_d      = ((state_d == S_SETUP) || (state_d == S_HIGH)) && word_a_d[0];
        sh_b_d      = ((state_d == S_SETUP) || (state_d == S_HIGH)) && word_b_d[0];
    end

`ifdef PMCC_SEQ_STROBE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) strobe <= 1'b0;
        else        strobe <= (state_d == S_STROBE);
    end
`else
    assign strobe = 1'b0;
`endif

endmodule

// File: tb/tb_pmcc_shift_sequencer.sv
// Bench for pmcc_shift_sequencer: builds the expected per-cycle output trace of each
// sequence from the shifting rules and compares it cycle by cycle (honours PMCC_SEQ_STROBE_EN).
module tb_pmcc_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  bit_count = '0;
    logic [7:0]  half_period = '0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready, clk_sh, sh_a, sh_b, strobe, busy, done;

    always #5 clk = ~clk;

    pmcc_shift_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .bit_count(bit_count), .half_period(half_period),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .clk_sh(clk_sh), .sh_a(sh_a), .sh_b(sh_b), .strobe(strobe),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic busy; logic done; logic din_ready; logic clk_sh;
        logic sh_a; logic sh_b; logic strobe;
    } obs_t;
    typedef struct packed {
        logic start; logic abort; logic din_valid; logic [31:0] din;
    } stim_t;

    localparam obs_t  IDLE_O = '0;
    localparam stim_t IDLE_S = '{start: 1'b0, abort: 1'b0, din_valid: 1'b0, din: 32'hDEAD_BEEF};

    int          checks = 0;
    int          failures = 0;
    int          pulses = 0;
    logic [31:0] words [4];
    int          waits [4];
    obs_t        exp_a [$];
    stim_t       stim_a [$];

    function automatic obs_t mk(input logic bz, input logic dn, input logic rd, input logic ck,
                                input logic a, input logic b, input logic st);
        return {bz, dn, rd, ck, a, b, st};
    endfunction

    task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, want);
        end
    endtask

    // Expected trace: LOAD (with wait cycles), then H setup + H high per bit, word by word
    task automatic build(input int n, input int hp);
        int h;
        int used;
        int w;
        logic [31:0] wd;
        stim_t s;
        h = (hp == 0) ? 1 : hp;
        used = 0;
        w = 0;
        exp_a.delete();
        stim_a.delete();
        s = IDLE_S;
        s.start = 1'b1;
        stim_a.push_back(s);
        while (used < n) begin
            wd = words[w];
            for (int k = 0; k <= waits[w]; k++) begin
                exp_a.push_back(mk(1, 0, 1, 0, 0, 0, 0));
                s = IDLE_S;
                if (k == waits[w]) begin
                    s.din_valid = 1'b1;
                    s.din = wd;
                end
                stim_a.push_back(s);
            end
            for (int b = 0; b < 16 && used < n; b++) begin
                repeat (h) begin
                    exp_a.push_back(mk(1, 0, 0, 0, wd[b], wd[b+16], 0));
                    stim_a.push_back(IDLE_S);
                end
                repeat (h) begin
                    exp_a.push_back(mk(1, 0, 0, 1, wd[b], wd[b+16], 0));
                    stim_a.push_back(IDLE_S);
                end
                used++;
            end
            w++;
        end
`ifdef PMCC_SEQ_STROBE_EN
        if (n > 0) begin
            repeat (h) begin
                exp_a.push_back(mk(1, 0, 0, 0, 0, 0, 1));
                stim_a.push_back(IDLE_S);
            end
        end
`endif
        exp_a.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        stim_a.push_back(IDLE_S);
        repeat (2) begin
            exp_a.push_back(IDLE_O);
            stim_a.push_back(IDLE_S);
        end
    endtask

    // Abort at edge a: outputs quiet and idle from then on
    task automatic truncate_abort(input int a);
        stim_t s;
        while (exp_a.size() > a) void'(exp_a.pop_back());
        while (stim_a.size() > a) void'(stim_a.pop_back());
        repeat (3) exp_a.push_back(IDLE_O);
        s = IDLE_S;
        s.abort = 1'b1;
        s.start = (a == 0);
        stim_a.push_back(s);
    endtask

    task automatic apply(input stim_t s);
        start = s.start;
        abort = s.abort;
        din_valid = s.din_valid;
        din = s.din;
    endtask

    // Drive the stimulus and compare every cycle against the expected trace
    task automatic execute(input string name, input int n, input int hp);
        obs_t cur;
        logic prev;
        pulses = 0;
        prev = clk_sh;
        @(negedge clk);
        #1;
        bit_count = 10'(n);
        half_period = 8'(hp);
        apply(stim_a[0]);
        for (int i = 0; i < exp_a.size(); i++) begin
            @(negedge clk);
            cur = {busy, done, din_ready, clk_sh, sh_a, sh_b, strobe};
            check(name, i, 32'(cur), 32'(exp_a[i]));
            if (clk_sh && !prev) pulses++;
            prev = clk_sh;
            #1;
            bit_count = 10'($urandom);
            half_period = 8'($urandom);
            if (i + 1 < stim_a.size()) apply(stim_a[i+1]);
            else apply(IDLE_S);
        end
    endtask

    initial begin
        logic [3:0] pa;
        logic [3:0] pb;
        int cnt;
        int loads;
        for (int i = 0; i < 4; i++) begin
            words[i] = '0;
            waits[i] = 0;
        end
        #1;
        check("reset_outputs", 0, 32'({busy, done, din_ready, clk_sh, sh_a, sh_b, strobe}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 4-bit sequence with a start while busy that must be ignored
        words[0] = 32'h0005_000A;
        build(4, 2);
        stim_a[6].start = 1'b1;
`ifdef PMCC_SEQ_STROBE_EN
        check("model_len4", 0, 32'(exp_a.size()), 32'd22);
`else
        check("model_len4", 0, 32'(exp_a.size()), 32'd20);
`endif
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            pa[i] = exp_a[3 + 4*i].sh_a;
            pb[i] = exp_a[3 + 4*i].sh_b;
        end
        for (int i = 0; i < exp_a.size(); i++) if (exp_a[i].clk_sh) cnt++;
        check("model_sh_a", 0, 32'(pa), 32'h5 << 1);
        check("model_sh_b", 0, 32'(pb), 32'h5);
        check("model_high_cycles", 0, 32'(cnt), 32'd8);
        execute("basic4", 4, 2);
        check("basic4_pulses", 0, 32'(pulses), 32'd4);

        // Two words with a 10-cycle data stall before the second
        words[0] = 32'h1234_A5C3;
        words[1] = 32'h00FF_0F0F;
        waits[1] = 10;
        build(20, 1);
        loads = 0;
        for (int i = 0; i < exp_a.size(); i++) if (exp_a[i].din_ready) loads++;
        check("model_load_cycles", 0, 32'(loads), 32'd12);
        execute("stall20", 20, 1);
        check("stall20_pulses", 0, 32'(pulses), 32'd20);
        waits[1] = 0;

        // Zero-length request completes immediately
        build(0, 3);
        check("model_len0", 0, 32'(exp_a.size()), 32'd3);
        execute("zero_len", 0, 3);
        check("zero_len_pulses", 0, 32'(pulses), 32'd0);

        // Abort during HIGH of bit 3, then a clean rerun
        words[0] = 32'h0F0F_F0F0;
        build(8, 2);
        check("model_abort_pt", 0, 32'(exp_a[15].clk_sh), 32'd1);
        truncate_abort(16);
        execute("abort_high", 8, 2);
        build(8, 2);
        execute("after_abort", 8, 2);
        check("after_abort_pulses", 0, 32'(pulses), 32'd8);

        // Abort wins over a simultaneous start
        build(4, 2);
        truncate_abort(0);
        execute("abort_prio", 4, 2);

        // Minimum phases with half_period of 0; strobe only when enabled
        words[0] = 32'h0002_0001;
        build(2, 0);
`ifdef PMCC_SEQ_STROBE_EN
        check("model_strobe_pos", 0, 32'({exp_a[5].strobe, exp_a[6].done}), 32'b11);
`else
        check("model_done_pos", 0, 32'({exp_a[5].strobe, exp_a[5].done}), 32'b01);
`endif
        execute("hp0", 2, 0);
        check("hp0_pulses", 0, 32'(pulses), 32'd2);

        // Asynchronous reset mid-sequence
        words[0] = 32'hFFFF_FFFF;
        build(8, 2);
        while (exp_a.size() > 10) void'(exp_a.pop_back());
        execute("rst_pre", 8, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 0, 32'({busy, done, din_ready, clk_sh, sh_a, sh_b, strobe}), 32'(0));
        @(negedge clk);
        check("rst_hold", 0, 32'({busy, done, din_ready, clk_sh, sh_a, sh_b, strobe}), 32'(0));
        rst_n = 1'b1;
        exp_a.delete();
        stim_a.delete();
        repeat (3) exp_a.push_back(IDLE_O);
        stim_a.push_back(IDLE_S);
        execute("rst_post", 0, 0);

        words[0] = 32'h0005_000A;
        build(4, 2);
        execute("post_reset_run", 4, 2);
        check("post_reset_pulses", 0, 32'(pulses), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
